// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared types and constants for the instruction fetch unit.
//   u1/u6/u32      : plain scalar/vector aliases used across the core
//   fetch_state_t  : RUN (no stale responses pending) / DRAIN (discarding stale responses)
//   INSTR_BYTES    : byte stride between consecutive instruction words
//   word_align()   : clears the byte-offset bits of an address
package instr_fetch_pkg;

    typedef logic        u1;
    typedef logic [5:0]  u6;
    typedef logic [31:0] u32;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    localparam u32 INSTR_BYTES = 32'd4;

    function automatic u32 word_align(input u32 addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// instr_fetch_fifo: small synchronous FIFO holding {pc, word} entries for the fetch unit.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_clear      : synchronous flush; wins over push and pop
//   i_push       : write i_wdata (caller guarantees space, or a same-cycle pop)
//   i_pop        : drop the head entry (ignored when empty)
//   i_wdata      : entry to write
//   o_rdata      : head entry (registered storage, no bypass)
//   o_count      : number of stored entries
//   o_empty      : no entries
//   o_full       : DEPTH entries stored
module instr_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdata,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_empty,
    output logic          o_full
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty && !i_clear;
    assign w_do_push = i_push && !i_clear;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: only entries below r_count are ever observed.
    always_ff @(posedge clk) begin
        if (w_do_push && !reset) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit for the single-cycle MIPS core.
// Holds the fetch PC, issues word requests to instruction memory, buffers the
// in-order responses and presents the head instruction to the decoder.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   imem_req_valid/ready/addr       : request channel to instruction memory
//   imem_resp_valid/data            : in-order response channel (no backpressure)
//   instr_valid/ready, instr,
//   instr_pc, op                    : head instruction towards the decoder
//   redirect, redirect_pc           : taken branch / jump; flush and refetch
//   dbg_state                       : 1 while stale responses are being discarded
//
// Handshakes: a transfer happens in a cycle where valid and ready are both 1 at
// the rising edge. Valid never depends on ready. The response channel has no
// ready; every imem_resp_valid cycle is one response, returned in request order.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  op,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    u32            r_fetch_pc;
    u32            r_resp_pc;       // pc of the next new-path response
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic [63:0]   w_head;
    logic          w_accept;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_out_next;
    u32            w_redirect_pc;
    logic          w_unused_pc_lsbs;

    // Credit uses registered occupancy only: a pop in this cycle frees no slot
    // until the next one, keeping the request path free of decoder timing.
    assign imem_req_valid = !reset &&
        (({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;

    assign w_accept      = imem_req_valid && imem_req_ready;
    assign w_pop         = !w_empty && instr_ready;
    // A response arriving together with a redirect belongs to the old path.
    assign w_push        = imem_resp_valid && (r_state == RUN) && !redirect &&
                           (!w_full || w_pop);
    assign w_out_next    = r_outstanding + CW'(w_accept) - CW'(imem_resp_valid);
    assign w_redirect_pc = word_align(redirect_pc);
    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    instr_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (64)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({r_resp_pc, imem_resp_data}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
            end
            if (redirect) begin
                // Everything still in flight after this edge (including a
                // request accepted now) is old-path and must be discarded.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_drop_cnt <= w_out_next;
                r_state    <= (w_out_next != '0) ? DRAIN : RUN;
            end else begin
                case (r_state)
                    RUN: begin
                        if (imem_resp_valid) begin
                            r_resp_pc <= r_resp_pc + INSTR_BYTES;
                        end
                    end
                    DRAIN: begin
                        if (imem_resp_valid) begin
                            r_drop_cnt <= r_drop_cnt - CW'(1);
                            if (r_drop_cnt == CW'(1)) begin
                                r_state <= RUN;
                            end
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    assign instr_valid = !w_empty;
    assign instr       = w_empty ? 32'h0 : w_head[31:0];
    assign instr_pc    = w_empty ? 32'h0 : w_head[63:32];
    assign op          = instr[31:26];
    assign dbg_state   = (r_state == DRAIN);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-cycle MIPS core. It produces the instruction stream that feeds the main decoder: it holds the PC, issues word requests to instruction memory over a valid/ready handshake, and buffers in-order responses in a small FIFO. It presents `instr`/`op` to the decoder, and it accepts branch/jump redirects resolved from the decoder's `jump`/branch controls.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 4: instruction buffer entries; also the cap on (buffered + outstanding); power of 2, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word address of the request; bits [1:0] always 0.
- `imem_resp_valid` in 1: response valid; responses are in order and cannot be backpressured.
- `imem_resp_data` in 32: instruction word.
- `instr_valid` out 1: `instr`/`instr_pc`/`op` valid.
- `instr_ready` in 1: decoder/datapath consumes the head instruction.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: address of the head instruction.
- `op` out 6: `instr[31:26]`, wired to the decoder `op`.
- `redirect` in 1: taken branch or jump; flush and refetch.
- `redirect_pc` in 32: new fetch address; bits [1:0] are ignored and treated as 0.

## Operation
- Registers: `fetch_pc` (u32), `outstanding` (accepted requests not yet responded), `drop_cnt` (stale responses still to discard), FIFO of {pc, word} with `count`, state.
- States:
  - RUN: `drop_cnt` == 0.
  - DRAIN: `drop_cnt` > 0; arriving responses are discarded and decrement `drop_cnt`.
  - DRAIN→RUN when `drop_cnt` reaches 0.
- Issue: `imem_req_valid` = !reset && (`count` + `outstanding` < `DEPTH`), using registered values only; a same-cycle pop gives no credit.
- `imem_req_addr` = `fetch_pc`. On accept (valid && ready):
  - `fetch_pc` += 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0);
  - `outstanding` += 1.
- Issue continues in both RUN and DRAIN. New-path responses always arrive after the stale ones.
- Response:
  - `outstanding` -= 1.
  - In RUN: push {pc, word}. The pc comes from a pc FIFO written at request accept, or equivalently is tracked as pc-of-next-response += 4.
  - In DRAIN: discard.
  - Push into a full FIFO cannot happen by construction; the bench asserts this.
- Consume: pop when `instr_valid` && `instr_ready`.
- Redirect (highest priority) in cycle T:
  - FIFO cleared, so `count` becomes 0.
  - `fetch_pc` = {`redirect_pc`[31:2], 2'b00}.
  - `drop_cnt` = `outstanding` + (request accepted in T) − (response arriving in T while in RUN or DRAIN that is counted as stale).
  - In effect, every response belonging to a request accepted at or before T is dropped.
  - A request accepted in T carries the old `fetch_pc` and is stale.
  - A response arriving in T is discarded.
  - A pop in T is still a valid consume of the old head.
- Redirect while already in DRAIN: `drop_cnt` is recomputed by the same rule, accumulating all outstanding requests.
- `op`, `instr`, `instr_pc` are driven from the FIFO head. They are don't-care when `instr_valid` = 0 and are driven to 0 for determinism.

## Timing
- Reset values:
  - `imem_req_valid` = 0, `instr_valid` = 0, `instr`/`instr_pc`/`op` = 0;
  - `fetch_pc` = `RESET_PC`; `outstanding` = `drop_cnt` = `count` = 0; state RUN.
- First request is asserted in the first cycle after `reset` deasserts, with address `RESET_PC`.
- Response→`instr_valid`: 1 cycle (registered FIFO, no bypass).
- Redirect in T:
  - `instr_valid` = 0 in T+1;
  - `imem_req_addr` = `redirect_pc` in T+1;
  - earliest new-path `instr_valid` is T+1 + memory latency + 1.
- Throughput: with 1-cycle memory latency, `DEPTH` = 4 and `instr_ready` held high, one instruction per cycle is sustained.
- Reset mid-operation: all state is cleared. Responses to pre-reset requests are the environment's responsibility; memory is reset in the same cycle.

## Structure
- `common.svh`: u1/u6/u32 typedefs (existing), the `fetch_state_t` enum {RUN, DRAIN}, and the `INSTR_BYTES` = 4 constant. Opcode macros stay where they are.
- One sub-module, `fetch_fifo`: parameterised `DEPTH`, 64-bit {pc, word} entries, with push, pop, synchronous clear, `count`, `empty`, `full`. Clear takes priority over push and pop.
- Counter widths are $clog2(`DEPTH`)+1.

## Test plan
- **Reset/straight line:** memory always ready, latency 1, `instr_ready` = 1 → requests 0x0, 0x4, 0x8, …. `instr_pc` sequence 0x0, 0x4, … starting 2 cycles after the first request. One instr/cycle; `op` = word[31:26].
- **Backpressure:** `instr_ready` = 0 for 10 cycles → exactly `DEPTH` (4) entries fill, `imem_req_valid` drops, no overflow. Release gives in-order pcs with no gaps or duplicates.
- **Redirect with in-flight requests:** latency 3, redirect to 0x100 while `outstanding` = 3 → 3 stale responses dropped. The first `instr_pc` after redirect is 0x100, followed by 0x104.
- **Simultaneous events:** redirect in the same cycle as request accept, response, and pop → the popped instr counts as consumed, the accepted request is dropped, and no stale pc ever appears on `instr_pc`.
- **Back-to-back redirects:** 0x200 then 0x300 one cycle apart, during DRAIN → only pcs ≥ 0x300 appear. `redirect_pc` = 0x303 fetches 0x300.
- **Wrap and mid-run reset:** redirect to 0xFFFF_FFF8 → pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Reset asserted mid-stream → next cycle `instr_valid` = 0, and the first request after release is `RESET_PC`.
